lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store unit: the initiator side of the word-addressed data memory interface (MemRead / MemWrite / addr / write_data / read_data).
- Accepts one core request at a time and converts byte, halfword and word loads/stores into word accesses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the execute stage and data memory; memory read data is combinational, writes commit on posedge clk.

Parameters:
ADDR_W, 32, width of byte address from core and to memory

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  LSU can accept request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  result available
resp_ready  input  1  core consumes result
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal request
MemRead  output  1  to memory
MemWrite  output  1  to memory
mem_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
mem_wdata  output  32  word to write
mem_rdata  input  32  combinational memory read data

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0. Core must not issue while rst high.
- Little-endian: byte offset k = bits [8k+7:8k].
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - On req_valid, latch store flag, funct3, addr and wdata.
  - Illegal request (funct3 011/110/111, or store with 100/101) -> RESP with err.
  - Misaligned request (H with addr[0]=1, W with addr[1:0]!=0) -> RESP with err.
  - SW -> WRITE.
  - Any load or SB/SH -> ACCESS.
- ACCESS: MemRead=1 for exactly this cycle; capture mem_rdata at the edge.
  - Load: extract lane by addr[1:0], extend (B/H signed, BU/HU zero), -> RESP.
  - SB/SH: -> WRITE.
- WRITE: MemWrite=1 for exactly this cycle.
  - mem_wdata = req_wdata for SW.
  - For SB/SH, mem_wdata = captured word with the addressed byte/half replaced.
  - Next state RESP.
- RESP: resp_valid=1; rdata/err held stable until resp_ready. On resp_valid&resp_ready -> IDLE.
- MemRead/MemWrite never both high. Neither is asserted for erroneous requests: no memory side effect.
- Latency from accept edge to resp_valid:
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Loads: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: next request is accepted one cycle after the response handshake (IDLE re-entered).
- mem_addr is held at the latched word address from ACCESS through RESP.
- Reset in ACCESS or WRITE aborts the operation. A reset asserted before the WRITE edge produces no write. A partially completed RMW is never committed later.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB 0x11 -> resp_rdata 0xFFFFFFAA, err 0; LBU 0x11 -> 0x000000AA; MemRead pulses 1 cycle, resp_valid 2 cycles after accept.
- LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB.
- SB 0x13 wdata 0x12345655 -> one MemRead cycle then one MemWrite with mem_wdata 0x5599AABB; resp 3 cycles after accept. SH 0x10 wdata 0x0000CAFE -> 0x5599CAFE. SW 0x14 0xDEADBEEF -> single MemWrite, no MemRead.
- SH 0x11 and LW 0x12 -> resp_err=1, rdata 0, MemRead/MemWrite never asserted, memory unchanged. funct3 011 -> same.
- Hold resp_ready=0 for 5 cycles after LB -> resp_valid/resp_rdata stable, req_ready=0. Release -> IDLE, req_ready=1 next cycle.
- Assert rst during ACCESS of SB 0x13 -> all outputs to reset values immediately, no MemWrite, word 0x10 unchanged; next LW 0x10 completes normally.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Brief    : Load/store unit initiator for a word-addressed data memory.
//            Handles byte/half/word access with read-modify-write sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_write  = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    logic [1:0]  r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [15:0] r_wdata_lo;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Request decode works on the live inputs, only consulted in IDLE.
    always_comb begin
        w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_store && req_funct3[2]);
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == c_f3_w) && (req_addr[1:0] != 2'b00));
        w_bad      = w_illegal || w_misalign;
    end

    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_funct3)
            c_f3_b:  w_load = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: w_load = {24'd0, w_byte};
            c_f3_h:  w_load = {{16{w_half[15]}}, w_half};
            c_f3_hu: w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Only SB (funct3[0]=0) and SH (funct3[0]=1) ever reach the merge path.
    always_comb begin
        w_merge = mem_rdata;
        if (r_funct3[0]) begin
            w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata_lo;
        end else begin
            w_merge[{r_off, 3'b000} +: 8] = r_wdata_lo[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_store    <= 1'b0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_wdata_lo <= 16'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_store    <= req_store;
                        r_funct3   <= req_funct3;
                        r_off      <= req_addr[1:0];
                        r_wdata_lo <= req_wdata[15:0];
                        req_ready  <= 1'b0;
                        if (w_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            r_state    <= c_st_resp;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_store && (req_funct3 == c_f3_w)) begin
                                MemWrite  <= 1'b1;
                                mem_wdata <= req_wdata;
                                r_state   <= c_st_write;
                            end else begin
                                MemRead <= 1'b1;
                                r_state <= c_st_access;
                            end
                        end
                    end
                end
                c_st_access: begin
                    MemRead <= 1'b0;
                    if (r_store) begin
                        MemWrite  <= 1'b1;
                        mem_wdata <= w_merge;
                        r_state   <= c_st_write;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= w_load;
                        r_state    <= c_st_resp;
                    end
                end
                c_st_write: begin
                    MemWrite   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    r_state    <= c_st_resp;
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                        req_ready  <= 1'b1;
                        r_state    <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Brief    : Directed and randomized checks of lsu_mem_initiator against a
//            word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    int checks = 0;
    int errors = 0;
    int rd_cnt, wr_cnt, both_cnt;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (MemRead) rd_cnt++;
        if (MemWrite) begin
            wr_cnt++;
            last_wdata = mem_wdata;
            mem[mem_addr[5:2]] <= mem_wdata;
        end
        if (MemRead && MemWrite) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the access rules, on the shadow memory.
    task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output bit err, output bit [31:0] rdata,
                         output bit [31:0] nw, output int lat, output int nr, output int nwr);
        bit [31:0] word, b, h, mask;
        int sh, size;
        bit illegal, mis;
        word = ref_mem[a[5:2]];
        sh = 8 * int'(a[1:0]);
        nw = word; rdata = 0; nr = 0; nwr = 0;
        illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4);
        size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        mis = (int'(a[1:0]) % size) != 0;
        err = illegal || mis;
        b = (word >> sh) & 32'hFF;
        h = (word >> sh) & 32'hFFFF;
        if (err) begin
            lat = 1;
        end else if (!st) begin
            nr = 1; lat = 2;
            case (f3)
                3'd0:    rdata = b + ((b >= 128) ? 32'hFFFFFF00 : 32'h0);
                3'd4:    rdata = b;
                3'd1:    rdata = h + ((h >= 32768) ? 32'hFFFF0000 : 32'h0);
                3'd5:    rdata = h;
                default: rdata = word;
            endcase
        end else if (f3 == 2) begin
            nwr = 1; lat = 2; nw = wd;
        end else begin
            nr = 1; nwr = 1; lat = 3;
            mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
            nw = (word & ~mask) | ((wd << sh) & mask);
        end
    endtask

    task automatic do_req(input bit st, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input int hold, output bit [31:0] got);
        bit e_err; bit [31:0] e_rd, e_nw; int e_lat, e_nr, e_nwr, lat;
        model(st, f3, a, wd, e_err, e_rd, e_nw, e_lat, e_nr, e_nwr);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; last_wdata = 0;
        req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, e_lat);
        check("resp_valid", resp_valid, 1);
        check("resp_rdata", resp_rdata, e_rd);
        check("resp_err", resp_err, e_err);
        check("req_ready_busy", req_ready, 0);
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, e_rd);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        check("post_valid", resp_valid, 0);
        check("post_req_ready", req_ready, 1);
        check("read_pulses", rd_cnt, e_nr);
        check("write_pulses", wr_cnt, e_nwr);
        check("rd_wr_overlap", both_cnt, 0);
        if (e_nwr != 0) check("mem_wdata", last_wdata, e_nw);
        ref_mem[a[5:2]] = e_nw;
        check("mem_word", mem[a[5:2]], ref_mem[a[5:2]]);
    endtask

    initial begin
        bit [31:0] got;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
        rst = 1; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0;
        req_wdata = 0; resp_ready = 0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_memread", MemRead, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        do_req(0, 3'd0, 32'h11, 0, 0, got); check("lb_const", got, 32'hFFFFFFAA);
        do_req(0, 3'd4, 32'h11, 0, 0, got); check("lbu_const", got, 32'h000000AA);
        do_req(0, 3'd1, 32'h12, 0, 0, got); check("lh_const", got, 32'hFFFF8899);
        do_req(0, 3'd5, 32'h12, 0, 0, got); check("lhu_const", got, 32'h00008899);
        do_req(0, 3'd2, 32'h10, 0, 0, got); check("lw_const", got, 32'h8899AABB);
        do_req(1, 3'd0, 32'h13, 32'h12345655, 0, got); check("sb_const", mem[4], 32'h5599AABB);
        do_req(1, 3'd1, 32'h10, 32'h0000CAFE, 0, got); check("sh_const", mem[4], 32'h5599CAFE);
        do_req(1, 3'd2, 32'h14, 32'hDEADBEEF, 0, got); check("sw_const", mem[5], 32'hDEADBEEF);
        do_req(1, 3'd1, 32'h11, 32'hFFFF, 0, got);
        do_req(0, 3'd2, 32'h12, 0, 0, got);
        do_req(0, 3'd3, 32'h10, 0, 0, got);
        do_req(0, 3'd0, 32'h11, 0, 5, got);

        // Reset while the SB read phase is in flight must leave memory untouched.
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        req_valid = 1; req_store = 1; req_funct3 = 3'd0; req_addr = 32'h13; req_wdata = 32'hEE;
        @(posedge clk); #1;
        req_valid = 0;
        check("abort_in_access", MemRead, 1);
        rst = 1; #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_memread", MemRead, 0);
        check("abort_memwrite", MemWrite, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_wdata", mem_wdata, 0);
        @(posedge clk); @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        check("abort_no_write", wr_cnt, 0);
        check("abort_word", mem[4], 32'h5599CAFE);
        do_req(0, 3'd2, 32'h10, 0, 0, got); check("lw_after_abort", got, 32'h5599CAFE);

        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
